// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer and the decode bundle.
// Execution-state and op-code encodings live here so both sides agree on them.
package core_sequencer_pkg;

  typedef enum logic [1:0] {
    CORE_S   = 2'd0,
    STALL_S  = 2'd1,
    BRANCH_S = 2'd2
  } core_state_t;

  typedef enum logic [2:0] {
    INC = 3'd0,
    DEC = 3'd1,
    PSH = 3'd2,
    POP = 3'd3,
    MVR = 3'd4,
    MVL = 3'd5,
    CBF = 3'd6,
    CBB = 3'd7
  } op_code_t;

  localparam int STALL_CNT_W = 4;

endpackage

// File: rtl/core_sequencer_brace_depth_counter.sv
// Saturating up/down brace-nesting counter with synchronous clear,
// zero flag and a sticky overflow flag raised when an increment hits saturation.
module brace_depth_counter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               up,
  input  logic               down,
  output logic [DEPTH_W-1:0] depth,
  output logic               zero,
  output logic               overflow_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth        <= '0;
      overflow_err <= 1'b0;
    end else if (clr) begin
      depth <= '0;
    end else if (en && up) begin
      // Saturated: hold the count and latch the error until reset.
      if (&depth) overflow_err <= 1'b1;
      else        depth        <= depth + 1'b1;
    end else if (en && down && (depth != '0)) begin
      depth <= depth - 1'b1;
    end
  end

  assign zero = (depth == '0);

endmodule

// File: rtl/core_sequencer.sv
// Execution-state sequencer: turns decode state/pc_write requests into
// cycle-accurate CORE/STALL/BRANCH sequencing and gates decode side effects.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int DEPTH_W      = 8,
  parameter int STALL_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [2:0]         instruction,
  input  logic [1:0]         req_state,
  input  logic               req_pc_write,
  output logic [1:0]         seq_state,
  output logic               core_en,
  output logic               pc_write,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow_err
);

  localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(STALL_CYCLES - 1);

  core_state_t            state, state_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   stall_load, stall_dec;
  logic                   dc_en, dc_clr, dc_up, dc_down, dc_zero;
  logic                   core_en_c, pc_write_c;
  logic [DEPTH_W-1:0]     dc_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CORE_S;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_load)     stall_cnt <= STALL_LOAD;
      else if (stall_dec) stall_cnt <= stall_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_en_c  = 1'b0;
    pc_write_c = 1'b0;
    stall_load = 1'b0;
    stall_dec  = 1'b0;
    dc_clr     = 1'b0;
    dc_up      = 1'b0;
    dc_down    = 1'b0;
    case (state)
      CORE_S: begin
        core_en_c  = instr_valid;
        pc_write_c = instr_valid & req_pc_write;
        if (instr_valid) begin
          case (req_state)
            2'(STALL_S): begin
              state_nxt  = STALL_S;
              stall_load = 1'b1;
            end
            2'(BRANCH_S): begin
              state_nxt = BRANCH_S;
              dc_clr    = 1'b1;
            end
            default: state_nxt = CORE_S;
          endcase
        end
      end
      STALL_S: begin
        // The stalled instruction retires in the last stall cycle.
        pc_write_c = (stall_cnt == '0);
        if (stall_cnt == '0) state_nxt = CORE_S;
        else                 stall_dec = 1'b1;
      end
      BRANCH_S: begin
        pc_write_c = instr_valid;
        if (instr_valid) begin
          if (instruction == CBF) dc_up = 1'b1;
          if (instruction == CBB) begin
            if (dc_zero) begin
              state_nxt = CORE_S;
              dc_clr    = 1'b1;
            end else begin
              dc_down = 1'b1;
            end
          end
        end
      end
      default: state_nxt = CORE_S;
    endcase
  end

  assign dc_en = (state == BRANCH_S) & instr_valid;

  brace_depth_counter #(
    .DEPTH_W (DEPTH_W)
  ) u_depth (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (dc_en),
    .clr          (dc_clr),
    .up           (dc_up),
    .down         (dc_down),
    .depth        (dc_depth),
    .zero         (dc_zero),
    .overflow_err (overflow_err)
  );

  assign seq_state = state;
  assign depth     = (state == BRANCH_S) ? dc_depth : '0;
  assign core_en   = rst_n & core_en_c;
  assign pc_write  = rst_n & pc_write_c;

endmodule

// File: tb/tb_core_sequencer.sv
// Scenario bench for core_sequencer: a DEPTH_W=2/STALL_CYCLES=1 instance for the
// main scenarios plus a STALL_CYCLES=3 instance for the stall counter.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv;
  logic [2:0] instruction;
  logic [1:0] req_state;
  logic       req_pc_write;
  logic [1:0] seq_state;
  logic       core_en, pc_write, overflow_err;
  logic [1:0] depth;

  logic       b_iv;
  logic [2:0] b_instruction;
  logic [1:0] b_req_state;
  logic       b_req_pc_write;
  logic [1:0] b_seq_state;
  logic       b_core_en, b_pc_write, b_overflow_err;
  logic [7:0] b_depth;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q [$];
  logic [3:0] exp3_q [$];

  wire [6:0] obs  = {seq_state, core_en, pc_write, depth, overflow_err};
  wire [3:0] obs3 = {b_seq_state, b_core_en, b_pc_write};

  always #5 clk = ~clk;

  core_sequencer #(.DEPTH_W(2), .STALL_CYCLES(1)) dut (
    .clk (clk), .rst_n (rst_n), .instr_valid (iv), .instruction (instruction),
    .req_state (req_state), .req_pc_write (req_pc_write), .seq_state (seq_state),
    .core_en (core_en), .pc_write (pc_write), .depth (depth), .overflow_err (overflow_err)
  );

  core_sequencer #(.DEPTH_W(8), .STALL_CYCLES(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .instr_valid (b_iv), .instruction (b_instruction),
    .req_state (b_req_state), .req_pc_write (b_req_pc_write), .seq_state (b_seq_state),
    .core_en (b_core_en), .pc_write (b_pc_write), .depth (b_depth), .overflow_err (b_overflow_err)
  );

  function automatic logic [6:0] ev(core_state_t s, logic e, logic p, logic [1:0] d, logic o);
    return {s, e, p, d, o};
  endfunction

  // Drives one cycle on the main DUT, pushes its expectation, then pops and compares.
  task automatic run_seq(input string name, input int n, input logic ivs [16],
                         input op_code_t ops [16], input core_state_t rss [16],
                         input logic rpws [16], input logic [6:0] exs [16]);
    logic [6:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iv = ivs[i]; instruction = ops[i]; req_state = rss[i]; req_pc_write = rpws[i];
      exp_q.push_back(exs[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got {st,en,pw,dep,ovf}=%b, expected %b", name, i, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] e;
    rst_n = 1'b0; iv = 1'b1; instruction = CBF; req_state = BRANCH_S; req_pc_write = 1'b1;
    b_iv = 1'b1; b_instruction = POP; b_req_state = STALL_S; b_req_pc_write = 1'b1;
    exp_q.push_back(ev(CORE_S, 1'b0, 1'b0, 2'd0, 1'b0));
    #3;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset: got %b, expected %b", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1; iv = 1'b0; b_iv = 1'b0;
  endtask

  task automatic test_straight();
    logic ivs [16]; op_code_t ops [16]; core_state_t rss [16]; logic rpws [16]; logic [6:0] exs [16];
    ivs[0:3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    ops[0:3]  = '{INC, DEC, MVR, INC};
    rss[0:3]  = '{CORE_S, CORE_S, CORE_S, CORE_S};
    rpws[0:3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    exs[0:3]  = '{ev(CORE_S,1'b1,1'b1,2'd0,1'b0), ev(CORE_S,1'b1,1'b1,2'd0,1'b0),
                  ev(CORE_S,1'b1,1'b1,2'd0,1'b0), ev(CORE_S,1'b0,1'b0,2'd0,1'b0)};
    run_seq("straight", 4, ivs, ops, rss, rpws, exs);
  endtask

  task automatic test_stall();
    logic ivs [16]; op_code_t ops [16]; core_state_t rss [16]; logic rpws [16]; logic [6:0] exs [16];
    ivs[0:2]  = '{1'b1, 1'b1, 1'b0};
    ops[0:2]  = '{POP, CBF, INC};
    rss[0:2]  = '{STALL_S, BRANCH_S, CORE_S};
    rpws[0:2] = '{1'b0, 1'b1, 1'b0};
    exs[0:2]  = '{ev(CORE_S,1'b1,1'b0,2'd0,1'b0), ev(STALL_S,1'b0,1'b1,2'd0,1'b0),
                  ev(CORE_S,1'b0,1'b0,2'd0,1'b0)};
    run_seq("stall", 3, ivs, ops, rss, rpws, exs);
  endtask

  task automatic test_nested_branch();
    logic ivs [16]; op_code_t ops [16]; core_state_t rss [16]; logic rpws [16]; logic [6:0] exs [16];
    ivs[0:7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ops[0:7]  = '{CBF, INC, CBF, DEC, CBB, MVL, CBB, INC};
    rss[0:7]  = '{BRANCH_S, CORE_S, STALL_S, CORE_S, CORE_S, CORE_S, CORE_S, CORE_S};
    rpws[0:7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exs[0:7]  = '{ev(CORE_S,1'b1,1'b1,2'd0,1'b0),   ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0),
                  ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0), ev(BRANCH_S,1'b0,1'b1,2'd1,1'b0),
                  ev(BRANCH_S,1'b0,1'b1,2'd1,1'b0), ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0),
                  ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0), ev(CORE_S,1'b0,1'b0,2'd0,1'b0)};
    run_seq("nested", 8, ivs, ops, rss, rpws, exs);
  endtask

  task automatic test_bubbles();
    logic ivs [16]; op_code_t ops [16]; core_state_t rss [16]; logic rpws [16]; logic [6:0] exs [16];
    ivs[0:5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ops[0:5]  = '{CBF, CBF, CBB, CBB, CBB, INC};
    rss[0:5]  = '{BRANCH_S, CORE_S, CORE_S, CORE_S, CORE_S, CORE_S};
    rpws[0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exs[0:5]  = '{ev(CORE_S,1'b1,1'b1,2'd0,1'b0),   ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0),
                  ev(BRANCH_S,1'b0,1'b0,2'd1,1'b0), ev(BRANCH_S,1'b0,1'b1,2'd1,1'b0),
                  ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0), ev(CORE_S,1'b0,1'b0,2'd0,1'b0)};
    run_seq("bubbles", 6, ivs, ops, rss, rpws, exs);
  endtask

  task automatic test_saturation();
    logic ivs [16]; op_code_t ops [16]; core_state_t rss [16]; logic rpws [16]; logic [6:0] exs [16];
    ivs[0:10]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ops[0:10]  = '{CBF, CBF, CBF, CBF, CBF, CBB, CBB, CBB, CBB, INC, INC};
    rss[0:10]  = '{BRANCH_S, CORE_S, CORE_S, CORE_S, CORE_S, CORE_S, CORE_S, CORE_S, CORE_S,
                   CORE_S, CORE_S};
    rpws[0:10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exs[0:10]  = '{ev(CORE_S,1'b1,1'b1,2'd0,1'b0),   ev(BRANCH_S,1'b0,1'b1,2'd0,1'b0),
                   ev(BRANCH_S,1'b0,1'b1,2'd1,1'b0), ev(BRANCH_S,1'b0,1'b1,2'd2,1'b0),
                   ev(BRANCH_S,1'b0,1'b1,2'd3,1'b0), ev(BRANCH_S,1'b0,1'b1,2'd3,1'b1),
                   ev(BRANCH_S,1'b0,1'b1,2'd2,1'b1), ev(BRANCH_S,1'b0,1'b1,2'd1,1'b1),
                   ev(BRANCH_S,1'b0,1'b1,2'd0,1'b1), ev(CORE_S,1'b0,1'b0,2'd0,1'b1),
                   ev(CORE_S,1'b1,1'b1,2'd0,1'b1)};
    run_seq("saturation", 11, ivs, ops, rss, rpws, exs);
  endtask

  task automatic test_reset_mid_branch();
    logic ivs [16]; op_code_t ops [16]; core_state_t rss [16]; logic rpws [16]; logic [6:0] exs [16];
    logic [6:0] e;
    ivs[0:4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ops[0:4]  = '{CBF, CBF, CBF, CBF, INC};
    rss[0:4]  = '{BRANCH_S, CORE_S, CORE_S, CORE_S, CORE_S};
    rpws[0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exs[0:4]  = '{ev(CORE_S,1'b1,1'b1,2'd0,1'b1),   ev(BRANCH_S,1'b0,1'b1,2'd0,1'b1),
                  ev(BRANCH_S,1'b0,1'b1,2'd1,1'b1), ev(BRANCH_S,1'b0,1'b1,2'd2,1'b1),
                  ev(BRANCH_S,1'b0,1'b1,2'd3,1'b1)};
    run_seq("pre_reset", 5, ivs, ops, rss, rpws, exs);
    #2 rst_n = 1'b0;
    exp_q.push_back(ev(CORE_S, 1'b0, 1'b0, 2'd0, 1'b0));
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_branch: got %b, expected %b", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ivs[0] = 1'b1; ops[0] = INC; rss[0] = CORE_S; rpws[0] = 1'b1;
    exs[0] = ev(CORE_S, 1'b1, 1'b1, 2'd0, 1'b0);
    run_seq("post_reset", 1, ivs, ops, rss, rpws, exs);
  endtask

  task automatic test_stall_long();
    logic [3:0] e;
    logic [3:0] exs [6];
    exs = '{{CORE_S,1'b1,1'b0}, {STALL_S,1'b0,1'b0}, {STALL_S,1'b0,1'b0},
            {STALL_S,1'b0,1'b1}, {CORE_S,1'b1,1'b1}, {CORE_S,1'b0,1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_iv = (i < 5); b_instruction = (i == 0) ? POP : INC;
      b_req_state = (i == 0) ? STALL_S : CORE_S; b_req_pc_write = (i != 0);
      exp3_q.push_back(exs[i]);
      #1;
      e = exp3_q.pop_front();
      n_checks++;
      if (obs3 !== e) begin
        n_fail++;
        $display("FAIL stall_long[%0d]: got {st,en,pw}=%b, expected %b", i, obs3, e);
      end
    end
    b_iv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_nested_branch();
    test_bubbles();
    test_saturation();
    test_reset_mid_branch();
    test_stall_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Registered state machine that owns the core's execution state (CORE_S / STALL_S / BRANCH_S). It takes the state and pc_write requests from the combinational decode bundle and turns them into cycle-accurate sequencing. In BRANCH_S it scans forward for the matching CBB using a nesting-depth counter. It gates the decode bundle's side effects (core_en) and drives the final PC write enable. It sits between instruction fetch / decode and the PC / register write enables.

Parameters:
DEPTH_W, 8, width of the brace-nesting counter
STALL_CYCLES, 1, cycles spent in STALL_S before returning to CORE_S (legal range 1..15)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  fetched instruction on `instruction` is valid this cycle
instruction  input  3  op_code of current instruction
req_state  input  2  state requested by decode (core_state_t)
req_pc_write  input  1  pc_write requested by decode
seq_state  output  2  current registered state (core_state_t)
core_en  output  1  decode bundle write enables may take effect this cycle
pc_write  output  1  final PC write enable
depth  output  DEPTH_W  current nesting depth (BRANCH_S only, else 0)
overflow_err  output  1  sticky: CBF seen while depth saturated

Behaviour:
- One clock. Reset is asynchronous and active-low (`rst_n`).
- Reset values: seq_state=CORE_S, depth=0, stall counter=0, overflow_err=0.
- Combinational outputs core_en and pc_write are 0 while rst_n=0.
- Reset mid-branch or mid-stall: aborts immediately to CORE_S. No completion pulse is generated.
- State transitions occur only on the rising edge of clk. All outputs below are a function of the registered state plus the current inputs.

CORE_S:
- core_en = instr_valid
- pc_write = instr_valid & req_pc_write
- If instr_valid: next state = req_state. req_state=CORE_S stays in CORE_S.
- Entering BRANCH_S clears depth to 0. The triggering CBF has already been passed by its pc_write.
- Entering STALL_S loads the stall counter with STALL_CYCLES-1.
- instr_valid=0: hold state, all enables 0.
- Illegal req_state encoding (2'b11) is treated as CORE_S.

STALL_S:
- core_en = 0.
- pc_write = 1 only in the final stall cycle (counter==0). The stalled instruction is retired then.
- When counter==0, next state = CORE_S; otherwise the counter decrements.
- instr_valid is ignored.

BRANCH_S:
- core_en = 0.
- pc_write = instr_valid (skip every scanned instruction, including the matching CBB).
- Per valid instruction:
  - CBF: depth+1. If depth is already all-ones, depth holds and overflow_err sets (sticky until reset).
  - CBB with depth==0: matching brace; next state = CORE_S.
  - CBB with depth>0: depth-1.
  - Any other opcode: no change.
- instr_valid=0: hold, no change.
- On exit to CORE_S, depth returns to 0.

General:
- Latency: a state request is accepted in cycle N; the new state is visible on seq_state in cycle N+1.
- Sequencing and width rules:
  - depth arithmetic is unsigned DEPTH_W-bit; it never wraps.
  - The stall counter is 4 bits.
  - No simultaneous-event ambiguity: only one instruction is evaluated per cycle.

Decomposition:
- Shared definitions package:
  - core_state_t enum (CORE_S=0, STALL_S=1, BRANCH_S=2), reused by decode.
  - op_code enum (INC, DEC, PSH, POP, MVR, MVL, CBF, CBB).
- One sub-module is natural: brace_depth_counter. It holds the saturating up/down counter with clear, the zero flag and sticky overflow. It is instantiated once and enabled only in BRANCH_S.

Test Plan:
- Reset: hold rst_n=0 mid-BRANCH_S with depth=3 -> seq_state=CORE_S, depth=0, pc_write=0, core_en=0 asynchronously.
- Straight-line code: INC,DEC,MVR with req_state=CORE_S and req_pc_write=1 -> core_en=1 and pc_write=1 each cycle; seq_state stays CORE_S.
- Stall: POP with req_state=STALL_S and req_pc_write=0, STALL_CYCLES=1 -> next cycle seq_state=STALL_S, core_en=0, pc_write=1; following cycle CORE_S.
- Nested branch skip: CBF (acc_zero) then stream INC,CBF,DEC,CBB,MVL,CBB.
  - Expected depth sequence: 0,1,1,0,0, exit.
  - pc_write=1 on all 6 instructions.
  - CORE_S after the final CBB; core_en=0 throughout.
- Fetch bubbles in branch: BRANCH_S with instr_valid toggling 1,0,1 on CBF,x,CBB -> depth goes 1 then 0; no change and pc_write=0 during the bubble; state stays BRANCH_S.
- Saturation: DEPTH_W=2, feed 4 CBF in BRANCH_S -> depth saturates at 3; overflow_err=1 and remains 1 after returning to CORE_S, until rst_n.
